hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LAT, default 32, mul/div execute latency in cycles (legal 2..255).
REQ-002 SHALL have parameter CNT_W, default 32, width of stall performance counter.
REQ-003 SHALL have port clk  in  1  single pipeline clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port id_valid  in  1  ID stage holds a real instruction.
REQ-006 SHALL have ports id_rs / id_rt  in  5 each  source register fields of ID instruction.
REQ-007 SHALL have port id_muldiv  in  1  ID instruction is multiply/divide.
REQ-008 SHALL have port ex_memread  in  1  EX instruction is a load (MemRead bit of ID/EX M control).
REQ-009 SHALL have port ex_rt  in  5  destination field of EX instruction.
REQ-010 SHALL have port ex_branch_taken  in  1  branch in EX resolved taken.
REQ-011 SHALL have outputs pc_we, ifid_we, ifid_flush, idex_bubble  out  1 each; idex_bubble forces WB/M/EX control fields entering ID/EX to zero.
REQ-012 SHALL have outputs md_busy  out  1 and stall_cycles  out  CNT_W.

Function
REQ-013 Defaults, no hazard: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
REQ-014 Load-use hazard LU = id_valid & ex_memread & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt); SHALL be combinational, same cycle: pc_we=0, ifid_we=0, idex_bubble=1.
REQ-015 Branch taken SHALL give same cycle: ifid_flush=1, idex_bubble=1, pc_we=1, ifid_we=1; overrides LU and MD_WAIT front-end freeze.
REQ-016 FSM states RUN, MD_WAIT; reset state RUN.
REQ-017 RUN->MD_WAIT when id_valid & id_muldiv & !LU & !ex_branch_taken; mul/div advances into EX that edge; counter loads MD_LAT-1.
REQ-018 MD_WAIT: counter decrements each cycle; pc_we=0, ifid_we=0, idex_bubble=1, md_busy=1; MD_WAIT->RUN on edge where counter==1, so front end frozen exactly MD_LAT-1 cycles.
REQ-019 Branch taken while in MD_WAIT SHALL flush per REQ-015 without leaving MD_WAIT or altering counter.
REQ-020 Simultaneous LU and id_muldiv: LU wins; transition deferred to next cycle.
REQ-021 stall_cycles SHALL increment each cycle pc_we==0, saturate at all-ones, never wrap.
REQ-022 ex_rt==0 SHALL never cause stall.

Reset
REQ-023 rst in any state SHALL next cycle give: state RUN, counter 0, md_busy=0, stall_cycles=0; outputs then per REQ-013 unless LU/branch asserted.
REQ-024 rst during MD_WAIT SHALL abandon the wait immediately.

Configuration
REQ-025 Macro HAZARD_MULDIV_EN: defined -> FSM, counter, md_busy per REQ-016..020; undefined -> no FSM/counter, id_muldiv ignored, md_busy tied 0, only LU and branch logic.

Structure
REQ-026 Shared package pipe_pkg SHALL hold FSM state enum, REG_W=5, MD_LAT default constant.
REQ-027 Sub-module hazard_md_timer (load/decrement/done counter) SHALL be the only sub-module; instantiated only under HAZARD_MULDIV_EN.

Verification
REQ-028 ex_memread=1, ex_rt=8, id_rs=8, id_valid=1 -> same cycle pc_we=0, ifid_we=0, idex_bubble=1; next cycle (ex_memread=0) defaults; stall_cycles=1.
REQ-029 ex_memread=1, ex_rt=0, id_rt=0 -> no stall, stall_cycles unchanged.
REQ-030 LU and ex_branch_taken same cycle -> ifid_flush=1, idex_bubble=1, pc_we=1.
REQ-031 MD_LAT=4, id_muldiv pulse -> md_busy=1 and pc_we=0 for exactly 3 cycles, then RUN; stall_cycles=3.
REQ-032 rst asserted 2nd MD_WAIT cycle -> next cycle md_busy=0, pc_we=1, stall_cycles=0.
REQ-033 Build without HAZARD_MULDIV_EN, id_muldiv=1 -> md_busy=0, pc_we=1 throughout.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants and FSM state type for hazard control
package pipe_pkg;

    localparam int REG_W      = 5;
    localparam int MD_LAT_DEF = 32;
    // Wide enough for any mul/div latency up to 255.
    localparam int MD_CNT_W   = 8;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } md_state_e;

endpackage

// File: rtl/hazard_md_timer.sv
// rtl/hazard_md_timer.sv - load/decrement/done counter timing a mul/div front-end freeze
import pipe_pkg::*;

module hazard_md_timer #(
    parameter int W = MD_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_done
);

    localparam logic [W-1:0] LP_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - LP_ONE;
        end
    end

    // Done marks the last frozen cycle, so the FSM leaves on this edge.
    assign o_done = (r_count == LP_ONE);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / branch-flush / mul-div stall control with stall counter
// HAZARD_MULDIV_EN enables the mul/div wait FSM and timer; otherwise id_muldiv is ignored.
import pipe_pkg::*;

module hazard_ctrl #(
    parameter int MD_LAT = MD_LAT_DEF,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_muldiv,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] LP_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             w_lu;
    logic             w_md_freeze;
    logic [CNT_W-1:0] r_stall_cycles;

    // Register 0 is hardwired, so a load targeting it can never feed a consumer.
    assign w_lu = id_valid && ex_memread && (ex_rt != '0) &&
                  ((ex_rt == id_rs) || (ex_rt == id_rt));

`ifdef HAZARD_MULDIV_EN
    localparam logic [MD_CNT_W-1:0] LP_MD_LOAD = MD_CNT_W'(MD_LAT - 1);

    md_state_e r_state;
    md_state_e w_state_nxt;
    logic      w_md_start;
    logic      w_md_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_md_start  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (id_valid && id_muldiv && !w_lu && !ex_branch_taken) begin
                    w_state_nxt = ST_MD_WAIT;
                    w_md_start  = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                if (w_md_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    hazard_md_timer #(
        .W(MD_CNT_W)
    ) u_md_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_md_start),
        .i_load_val (LP_MD_LOAD),
        .i_dec      (r_state == ST_MD_WAIT),
        .o_done     (w_md_done)
    );

    assign w_md_freeze = (r_state == ST_MD_WAIT);
    assign md_busy     = w_md_freeze;
`else
    logic w_unused_md;

    assign w_unused_md = id_muldiv | (MD_LAT < 2);
    assign w_md_freeze = 1'b0;
    assign md_busy     = 1'b0;
`endif

    // A taken branch always refetches, overriding any front-end freeze.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (w_lu || w_md_freeze) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
        if (ex_branch_taken) begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (!pc_we && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + LP_CNT_ONE;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl (either HAZARD_MULDIV_EN build)
module tb_hazard_ctrl;

    localparam int MD_LAT  = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_MULDIV_EN
    localparam bit MD_ON = 1'b1;
`else
    localparam bit MD_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_muldiv;
    logic             ex_memread;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(
        .MD_LAT(MD_LAT),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_muldiv       (id_muldiv),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .md_busy         (md_busy),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: md_left = frozen cycles still owed to a mul/div; stalls = saturating count.
    bit model_valid = 1'b0;
    int md_left     = 0;
    int stalls      = 0;

    always @(negedge clk) begin
        bit lu, frz, br, e_pc;
        lu   = id_valid && ex_memread && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
        frz  = lu || (md_left > 0);
        br   = ex_branch_taken;
        e_pc = br || !frz;
        if (model_valid) begin
            chk("pc_we",        int'(pc_we),        int'(e_pc));
            chk("ifid_we",      int'(ifid_we),      int'(e_pc));
            chk("ifid_flush",   int'(ifid_flush),   int'(br));
            chk("idex_bubble",  int'(idex_bubble),  int'(br || frz));
            chk("md_busy",      int'(md_busy),      int'(md_left > 0));
            chk("stall_cycles", int'(stall_cycles), stalls);
        end
        if (rst) begin
            md_left     = 0;
            stalls      = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (!e_pc && stalls < CNT_MAX) stalls++;
            if (md_left > 0)
                md_left--;
            else if (MD_ON && id_valid && id_muldiv && !lu && !br)
                md_left = MD_LAT - 1;
        end
    end

    task automatic drive(input bit r, input bit v, input int rs, input int rt, input bit md,
                         input bit mr, input int ert, input bit br);
        @(posedge clk);
        #1;
        rst             = r;
        id_valid        = v;
        id_rs           = 5'(rs);
        id_rt           = 5'(rt);
        id_muldiv       = md;
        ex_memread      = mr;
        ex_rt           = 5'(ert);
        ex_branch_taken = br;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_muldiv = 0;
        ex_memread = 0; ex_rt = 0; ex_branch_taken = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("reset_stall", int'(stall_cycles), 0);
        chk("reset_pc_we", int'(pc_we), 1);
        chk("reset_md_busy", int'(md_busy), 0);

        // Load-use through rs, then released
        drive(0, 1, 8, 3, 0, 1, 8, 0);
        chk("lu_rs_pc_we", int'(pc_we), 0);
        chk("lu_rs_ifid_we", int'(ifid_we), 0);
        chk("lu_rs_bubble", int'(idex_bubble), 1);
        drive(0, 1, 8, 3, 0, 0, 8, 0);
        chk("lu_release_pc_we", int'(pc_we), 1);
        chk("lu_stall_one", int'(stall_cycles), 1);

        // Load-use through rt
        drive(0, 1, 1, 9, 0, 1, 9, 0);
        chk("lu_rt_pc_we", int'(pc_we), 0);
        // Register zero and invalid ID never stall
        drive(0, 1, 0, 0, 0, 1, 0, 0);
        chk("r0_pc_we", int'(pc_we), 1);
        drive(0, 0, 7, 7, 0, 1, 7, 0);
        chk("novalid_pc_we", int'(pc_we), 1);
        chk("r0_stall_unchanged", int'(stall_cycles), 2);

        // Branch overrides load-use
        drive(0, 1, 5, 5, 0, 1, 5, 1);
        chk("br_lu_flush", int'(ifid_flush), 1);
        chk("br_lu_bubble", int'(idex_bubble), 1);
        chk("br_lu_pc_we", int'(pc_we), 1);

        // Mul/div pulse: frozen exactly MD_LAT-1 cycles
        drive(0, 1, 2, 3, 1, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (!pc_we && md_busy) n++;
        end
        chk("md_frozen_cycles", n, MD_ON ? 3 : 0);
        chk("md_stall_total", int'(stall_cycles), MD_ON ? 5 : 2);

        // LU beats mul/div, then mul/div starts; branch mid-wait flushes without leaving
        drive(0, 1, 4, 4, 1, 1, 4, 0);
        chk("lu_md_busy", int'(md_busy), 0);
        drive(0, 1, 4, 4, 1, 0, 4, 0);
        idle();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("md_br_busy", int'(md_busy), MD_ON ? 1 : 0);
        chk("md_br_flush", int'(ifid_flush), 1);
        idle();
        idle();
        idle();
        chk("md_br_stall_total", int'(stall_cycles), MD_ON ? 8 : 3);

        // Reset on the second wait cycle abandons it
        drive(0, 1, 0, 0, 1, 0, 0, 0);
        idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("rst_md_busy", int'(md_busy), 0);
        chk("rst_pc_we", int'(pc_we), 1);
        chk("rst_stall", int'(stall_cycles), 0);

        // Counter saturates
        for (int i = 0; i < 20; i++) drive(0, 1, 6, 0, 0, 1, 6, 0);
        idle();
        chk("stall_saturate", int'(stall_cycles), CNT_MAX);

        // Mixed vectors checked by the model
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 3, 12, 0, 1, 12, 0);
        drive(0, 1, 3, 12, 1, 0, 12, 0);
        drive(0, 1, 3, 3, 0, 1, 3, 0);
        drive(0, 1, 31, 0, 0, 1, 31, 1);
        drive(0, 1, 1, 2, 1, 1, 3, 0);
        for (int i = 0; i < 6; i++) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
